// File: rtl/group_rr_scheduler_if.sv
// Request/release inputs and enable/address outputs between the pixel-group
// arbiters and the group round-robin scheduler.
interface group_rr_scheduler_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int ADD  = 2
);
    logic [ROWS-1:0][COLS-1:0] req_i;
    logic                      grp_release_i;
    logic [ROWS-1:0][COLS-1:0] enable_o;
    logic [ADD-1:0]            x_add_o;
    logic [ADD-1:0]            y_add_o;
    logic                      active_o;
    logic                      timeout_o;

    // Driven by the requesting side (group arbiters / testbench)
    modport master (
        output req_i, grp_release_i,
        input  enable_o, x_add_o, y_add_o, active_o, timeout_o
    );

    // Seen by the scheduler
    modport slave (
        input  req_i, grp_release_i,
        output enable_o, x_add_o, y_add_o, active_o, timeout_o
    );
endinterface

// File: rtl/group_rr_scheduler.sv
// Round-robin scheduler granting one pixel group at a time, holding the grant
// until release or hold timeout, with a one-cycle dead gap between grants.
module group_rr_scheduler #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ADD      = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    group_rr_scheduler_if.slave   bus
);
    localparam int N  = ROWS * COLS;
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           r_state;
    logic [FW-1:0]    r_lp;
    logic [CNT_W-1:0] r_holdCnt;

    logic [N-1:0]     w_reqFlat;
    logic             w_found;
    logic [FW-1:0]    w_win;
    logic [N-1:0]     w_oneHot;
    logic [ADD-1:0]   w_x;
    logic [ADD-1:0]   w_y;

    // Bit [r][c] of the packed request lands at flat position r*COLS+c
    assign w_reqFlat = bus.req_i;

    // Circular search from lp+1: first pass takes indices above lp, second wraps to 0..lp
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_reqFlat[i] && (FW'(i) > r_lp)) begin
                w_found = 1'b1;
                w_win   = FW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_reqFlat[i]) begin
                w_found = 1'b1;
                w_win   = FW'(i);
            end
        end
        w_oneHot = N'(1) << w_win;
        w_x      = ADD'(w_win % COLS);
        w_y      = ADD'(w_win / COLS);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_lp          <= FW'(N - 1);
            r_holdCnt     <= '0;
            bus.enable_o  <= '0;
            bus.x_add_o   <= '0;
            bus.y_add_o   <= '0;
            bus.active_o  <= 1'b0;
            bus.timeout_o <= 1'b0;
        end else begin
            bus.timeout_o <= 1'b0;
            case (r_state)
                IDLE, GAP: begin
                    r_holdCnt <= '0;
                    if (w_found) begin
                        r_state      <= ACTIVE;
                        r_lp         <= w_win;
                        bus.enable_o <= w_oneHot;
                        bus.x_add_o  <= w_x;
                        bus.y_add_o  <= w_y;
                        bus.active_o <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                        bus.enable_o <= '0;
                        bus.active_o <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Release wins over timeout when both land on the same cycle
                    if (bus.grp_release_i) begin
                        r_state      <= GAP;
                        r_holdCnt    <= '0;
                        bus.enable_o <= '0;
                        bus.active_o <= 1'b0;
                    end else if (r_holdCnt == CNT_W'(MAX_HOLD - 1)) begin
                        r_state       <= GAP;
                        r_holdCnt     <= '0;
                        bus.enable_o  <= '0;
                        bus.active_o  <= 1'b0;
                        bus.timeout_o <= 1'b1;
                    end else begin
                        r_holdCnt <= r_holdCnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_holdCnt    <= '0;
                    bus.enable_o <= '0;
                    bus.active_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_group_rr_scheduler.sv
// Directed-vector bench for group_rr_scheduler: table of per-cycle stimulus and
// hand-computed outputs, plus sequences for timeout and asynchronous reset.
module tb_group_rr_scheduler;
    logic clk_i;
    logic reset_i;

    group_rr_scheduler_if #(.ROWS(4), .COLS(4), .ADD(2)) bus ();

    group_rr_scheduler #(
        .ROWS(4), .COLS(4), .ADD(2), .MAX_HOLD(16), .CNT_W(8)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rel;
        logic [15:0] expEn;
        logic [1:0]  expX;
        logic [1:0]  expY;
        logic        expTo;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   vecCount  = 0;
    int   failCount = 0;

    task automatic addVec(input logic rst, input logic [15:0] req, input logic rel,
                          input logic [15:0] expEn, input logic [1:0] expX,
                          input logic [1:0] expY, input logic expTo, input string name);
        vec_t v;
        v.rst = rst; v.req = req; v.rel = rel; v.expEn = expEn;
        v.expX = expX; v.expY = expY; v.expTo = expTo; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expEn,
                               input logic [1:0] expX, input logic [1:0] expY,
                               input logic expTo);
        logic expAct;
        expAct = |expEn;
        vecCount++;
        if (bus.enable_o !== expEn || bus.x_add_o !== expX || bus.y_add_o !== expY ||
            bus.active_o !== expAct || bus.timeout_o !== expTo) begin
            failCount++;
            $display("[TB] FAIL %s: got en=%h x=%0d y=%0d act=%b to=%b, expected en=%h x=%0d y=%0d act=%b to=%b",
                     name, bus.enable_o, bus.x_add_o, bus.y_add_o, bus.active_o, bus.timeout_o,
                     expEn, expX, expY, expAct, expTo);
        end
    endtask

    // Drive inputs, let one rising edge happen, then sample 1 time unit later
    task automatic applyStimulus(input logic rst, input logic [15:0] req, input logic rel);
        reset_i           = rst;
        bus.req_i         = req;
        bus.grp_release_i = rel;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i           = 1'b1;
        bus.req_i         = '0;
        bus.grp_release_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset state", 16'h0000, 2'd0, 2'd0, 1'b0);
        reset_i = 1'b0;

        // Single request at [0][2], release, then idle with address held
        addVec(0, 16'h0004, 0, 16'h0004, 2'd2, 2'd0, 0, "grant [0][2]");
        addVec(0, 16'h0000, 0, 16'h0004, 2'd2, 2'd0, 0, "hold [0][2]");
        addVec(0, 16'h0000, 1, 16'h0000, 2'd2, 2'd0, 0, "release [0][2]");
        addVec(0, 16'h0000, 0, 16'h0000, 2'd2, 2'd0, 0, "idle addr held");
        addVec(0, 16'h0000, 1, 16'h0000, 2'd2, 2'd0, 0, "release ignored idle");
        // Round-robin among f=1,7,12
        addVec(1, 16'h1082, 0, 16'h0000, 2'd0, 2'd0, 0, "reset with req");
        addVec(0, 16'h1082, 0, 16'h0002, 2'd1, 2'd0, 0, "rr grant f1");
        addVec(0, 16'h1082, 0, 16'h0002, 2'd1, 2'd0, 0, "rr hold f1");
        addVec(0, 16'h1082, 1, 16'h0000, 2'd1, 2'd0, 0, "rr gap after f1");
        addVec(0, 16'h1082, 0, 16'h0080, 2'd3, 2'd1, 0, "rr grant f7");
        addVec(0, 16'h1082, 0, 16'h0080, 2'd3, 2'd1, 0, "rr hold f7");
        addVec(0, 16'h1082, 1, 16'h0000, 2'd3, 2'd1, 0, "rr gap after f7");
        addVec(0, 16'h1082, 0, 16'h1000, 2'd0, 2'd3, 0, "rr grant f12");
        addVec(0, 16'h0000, 0, 16'h1000, 2'd0, 2'd3, 0, "req drop keeps f12");
        addVec(0, 16'h1082, 1, 16'h0000, 2'd0, 2'd3, 0, "rr gap after f12");
        addVec(0, 16'h1082, 0, 16'h0002, 2'd1, 2'd0, 0, "rr regrant f1");
        addVec(0, 16'h1082, 0, 16'h0002, 2'd1, 2'd0, 0, "rr hold f1 again");
        addVec(0, 16'h1082, 1, 16'h0000, 2'd1, 2'd0, 0, "rr gap f1 again");
        addVec(0, 16'h1082, 0, 16'h0080, 2'd3, 2'd1, 0, "rr regrant f7");
        addVec(0, 16'h1082, 1, 16'h0000, 2'd3, 2'd1, 0, "one-cycle grant f7");
        addVec(0, 16'h0000, 0, 16'h0000, 2'd3, 2'd1, 0, "rr back to idle");
        // Wrap-around from lp=15
        addVec(1, 16'h0000, 0, 16'h0000, 2'd0, 2'd0, 0, "reset before wrap");
        addVec(0, 16'h8000, 0, 16'h8000, 2'd3, 2'd3, 0, "grant f15");
        addVec(0, 16'h4001, 1, 16'h0000, 2'd3, 2'd3, 0, "gap after f15");
        addVec(0, 16'h4001, 0, 16'h0001, 2'd0, 2'd0, 0, "wrap grant f0");
        addVec(0, 16'h4001, 1, 16'h0000, 2'd0, 2'd0, 0, "gap after f0");
        addVec(0, 16'h4001, 0, 16'h4000, 2'd2, 2'd3, 0, "grant f14");
        addVec(0, 16'h0000, 1, 16'h0000, 2'd2, 2'd3, 0, "gap after f14");
        addVec(0, 16'h0000, 0, 16'h0000, 2'd2, 2'd3, 0, "idle after wrap");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rel);
            checkOutput(vecs[i].name, vecs[i].expEn, vecs[i].expX, vecs[i].expY, vecs[i].expTo);
            reset_i = 1'b0;
        end

        // Timeout: single request at [1][1] (f=5), never released
        applyStimulus(1, 16'h0000, 0);
        checkOutput("reset before timeout", 16'h0000, 2'd0, 2'd0, 1'b0);
        applyStimulus(0, 16'h0020, 0);
        checkOutput("timeout grant f5", 16'h0020, 2'd1, 2'd1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(0, 16'h0020, 0);
            checkOutput($sformatf("timeout hold %0d", k), 16'h0020, 2'd1, 2'd1, 1'b0);
        end
        applyStimulus(0, 16'h0020, 0);
        checkOutput("timeout pulse in gap", 16'h0000, 2'd1, 2'd1, 1'b1);
        applyStimulus(0, 16'h0020, 0);
        checkOutput("regrant after timeout", 16'h0020, 2'd1, 2'd1, 1'b0);

        // Release on the 16th active cycle suppresses the timeout pulse
        for (int k = 1; k < 16; k++) begin
            applyStimulus(0, 16'h0020, 0);
            checkOutput($sformatf("release-race hold %0d", k), 16'h0020, 2'd1, 2'd1, 1'b0);
        end
        applyStimulus(0, 16'h0020, 1);
        checkOutput("release on last cycle", 16'h0000, 2'd1, 2'd1, 1'b0);
        applyStimulus(0, 16'h0020, 0);
        checkOutput("regrant after release", 16'h0020, 2'd1, 2'd1, 1'b0);

        // Asynchronous reset mid-ACTIVE, then [0][0] wins over [2][2]
        bus.req_i = 16'h0401;
        #3;
        reset_i = 1'b1;
        #1;
        checkOutput("async reset mid-active", 16'h0000, 2'd0, 2'd0, 1'b0);
        #1;
        reset_i = 1'b0;
        applyStimulus(0, 16'h0401, 0);
        checkOutput("post-reset grant f0", 16'h0001, 2'd0, 2'd0, 1'b0);
        applyStimulus(0, 16'h0401, 1);
        checkOutput("post-reset gap", 16'h0000, 2'd0, 2'd0, 1'b0);
        applyStimulus(0, 16'h0401, 0);
        checkOutput("post-reset grant f10", 16'h0400, 2'd2, 2'd2, 1'b0);
        applyStimulus(0, 16'h0000, 1);
        checkOutput("final gap", 16'h0000, 2'd2, 2'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end
endmodule
